// File: rtl/LUTRAM_DualPort.sv
// Distributed-RAM model with one byte-strobed write/read port and one read port.
// READ_LATENCY=0 gives combinational reads; any other value registers both read ports.
module LUTRAM_DualPort #(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 64,
   parameter int BYTE_WIDTH   = 8,
   parameter int READ_LATENCY = 0
) (
   input  logic                             clk,
   input  logic                             en_1,
   input  logic [ADDR_WIDTH-1:0]            addr_1,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] strobe,
   input  logic [DATA_WIDTH-1:0]            wdata,
   output logic [DATA_WIDTH-1:0]            rdata_1,
   input  logic                             en_2,
   input  logic [ADDR_WIDTH-1:0]            addr_2,
   output logic [DATA_WIDTH-1:0]            rdata_2
);
   localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (en_1) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (strobe[b]) begin
               mem_q[addr_1][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 0) begin : g_comb_rd
         assign rdata_1 = mem_q[addr_1];
         assign rdata_2 = en_2 ? mem_q[addr_2] : '0;
      end else begin : g_reg_rd
         logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;

         always_comb begin
            rd1_d = rd1_q;
            rd2_d = rd2_q;
            if (en_1) rd1_d = mem_q[addr_1];
            if (en_2) rd2_d = mem_q[addr_2];
         end

         always_ff @(posedge clk) begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
         end

         assign rdata_1 = rd1_q;
         assign rdata_2 = rd2_q;
      end
   endgenerate
endmodule

// File: rtl/lutram_sync_fifo.sv
// Single-clock valid/ready FIFO over a distributed RAM; head entry is read
// combinationally from RAM port 2, writes go through RAM port 1.
module lutram_sync_fifo #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   count
);
   localparam int PTR_W = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] DEPTH = PTR_W'(1 << ADDR_WIDTH);

   logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic                empty, full, push, pop;
   logic [DATA_WIDTH-1:0] ram_rdata_1_unused;

   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
      in_ready  = !full;
      out_valid = !empty;
      count     = wr_ptr_q - rd_ptr_q;
      // A flush or reset cycle must not leave a stray RAM write behind.
      push      = in_valid && in_ready && !flush && !reset;
      pop       = out_valid && out_ready && !flush;
      wr_ptr_d  = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push};
      rd_ptr_d  = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop};
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   LUTRAM_DualPort #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .BYTE_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(0)
   ) u_ram (
      .clk    (clk),
      .en_1   (push),
      .addr_1 (wr_ptr_q[ADDR_WIDTH-1:0]),
      .strobe ('1),
      .wdata  (in_data),
      .rdata_1(ram_rdata_1_unused),
      .en_2   (1'b1),
      .addr_2 (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata_2(out_data)
   );

   count_le_depth: assert property (@(posedge clk) disable iff (reset) count <= DEPTH);
   no_pop_when_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));
   head_stable: assert property (@(posedge clk) disable iff (reset || flush)
      (out_valid && !out_ready) |=> $stable(out_data));
endmodule

// File: tb/tb_lutram_sync_fifo.sv
// Directed bench for lutram_sync_fifo (depth 4): stimulus queues expected head
// data; a negedge monitor compares every popped entry in order.
module tb_lutram_sync_fifo;
   localparam int AW = 2;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic          in_ready, out_valid;
   logic [DW-1:0] in_data, out_data;
   logic [AW:0]   count;

   int vectors = 0;
   int errors  = 0;
   logic [DW-1:0] sb [$];

   lutram_sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // Monitor: a pop happens at the next posedge whenever out_valid & out_ready.
   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("pop_with_empty_scoreboard", out_data, '0);
            if (out_data === '0) begin
               errors++;
               $display("FAIL unexpected_pop: got 0x%0h, expected no entry", out_data);
            end
         end else begin
            chk("out_data", out_data, sb.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      step(); step();
      at_neg();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("rst_count",     {61'd0, count},     64'd0);
      step();
      reset = 1'b0;

      // Fill then drain in order
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 64'hA0 + 64'(i); sb.push_back(in_data);
         step();
      end
      in_valid = 1'b0;
      at_neg();
      chk("fill_count",    {61'd0, count},     64'd4);
      chk("fill_in_ready", {63'd0, in_ready},  64'd0);
      chk("fill_out_valid",{63'd0, out_valid}, 64'd1);
      step();
      out_ready = 1'b1;
      repeat (4) step();
      out_ready = 1'b0;
      at_neg();
      chk("drain_count",     {61'd0, count},     64'd0);
      chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
      step();

      // Full with push and pop requested together
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 64'hB0 + 64'(i); sb.push_back(in_data);
         step();
      end
      in_data = 64'hC0; out_ready = 1'b1; sb.push_back(in_data);
      at_neg();
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      chk("full_count",    {61'd0, count},    64'd4);
      step();
      at_neg();
      chk("full_pop_only_count", {61'd0, count}, 64'd3);
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      at_neg();
      chk("full_push_lands_count", {61'd0, count}, 64'd3);
      step();
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      at_neg();
      chk("full_drain_count", {61'd0, count}, 64'd0);
      step();

      // Push into empty: no bypass
      in_valid = 1'b1; in_data = 64'h55; sb.push_back(in_data);
      at_neg();
      chk("empty_push_out_valid0", {63'd0, out_valid}, 64'd0);
      step();
      in_valid = 1'b0;
      at_neg();
      chk("empty_push_out_valid1", {63'd0, out_valid}, 64'd1);
      chk("empty_push_out_data",   out_data,           64'h55);
      step();

      // Steady stream at count=1, pointers wrap several times
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; out_ready = 1'b1; in_data = 64'h100 + 64'(i); sb.push_back(in_data);
         at_neg();
         chk("stream_count", {61'd0, count}, 64'd1);
         step();
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      at_neg();
      chk("stream_end_count", {61'd0, count}, 64'd0);
      step();

      // Flush at count=3 with a push requested
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 64'hE0 + 64'(i); sb.push_back(in_data);
         step();
      end
      in_valid = 1'b0;
      at_neg();
      chk("pre_flush_count", {61'd0, count}, 64'd3);
      step();
      flush = 1'b1; in_valid = 1'b1; in_data = 64'hEE;
      sb.delete();
      step();
      flush = 1'b0; in_valid = 1'b0;
      at_neg();
      chk("flush_count",     {61'd0, count},     64'd0);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
      step();
      in_valid = 1'b1; in_data = 64'h77; sb.push_back(in_data);
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      at_neg();
      chk("post_flush_count", {61'd0, count}, 64'd0);
      step();

      // Reset mid-stream with a push asserted
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 64'hF0 + 64'(i); sb.push_back(in_data);
         step();
      end
      reset = 1'b1; in_data = 64'hFF;
      sb.delete();
      step();
      reset = 1'b0; in_valid = 1'b0;
      at_neg();
      chk("midrst_count",     {61'd0, count},     64'd0);
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      step();

      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
